// File: rtl/frame_scan_reader.sv
// rtl/frame_scan_reader.sv - raster-scan reader for the camera frame buffer BRAM
//
// Scans the H_RES x V_RES frame buffer once per frame while enable is high and
// presents the pixels as a vsync/address/frame_pixel stream for the detectors.
// The end of a frame is marked by address == H_RES*V_RES for one cycle with
// vsync low and frame_done high.
//
// Optional feature macro: TEST_PATTERN_EN (replaces BRAM data by a fixed box).
//
// Ports:
//   clk          pixel clock
//   rst_n        async active-low reset
//   enable       level; scan frames back-to-back while high
//   bram_addr    BRAM read address (holds outside the scan)
//   bram_dout    BRAM read data, valid RD_LAT cycles after bram_addr
//   vsync        1 = blanking/idle, 0 = frame in progress
//   address      address of frame_pixel, H_RES*V_RES at end of frame
//   frame_pixel  pixel data aligned with address
//   pixel_valid  address/frame_pixel/x/y carry a real pixel
//   x, y         column/row of the current pixel
//   frame_done   one-cycle pulse with the end-of-frame marker
module frame_scan_reader #(
  parameter int H_RES     = 320,
  parameter int V_RES     = 240,
  parameter int PIX_W     = 12,
  parameter int ADDR_W    = 17,
  parameter int RD_LAT    = 1,
  parameter int VSYNC_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [PIX_W-1:0]  bram_dout,
  output logic              vsync,
  output logic [ADDR_W-1:0] address,
  output logic [PIX_W-1:0]  frame_pixel,
  output logic              pixel_valid,
  output logic [8:0]        x,
  output logic [7:0]        y,
  output logic              frame_done
);

  localparam int N = H_RES * V_RES;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] EOF_ADDR  = ADDR_W'(N);

  typedef enum logic [2:0] {IDLE, VBLANK, SCAN, DRAIN, EOF} state_t;

  state_t            state_q, state_d;
  logic [15:0]       vcnt_q;
  logic [1:0]        dcnt_q;
  logic [ADDR_W-1:0] bram_addr_q;
  logic [8:0]        ix_q;
  logic [7:0]        iy_q;
  logic              vsync_q;
  logic              frame_done_q;

  // Read-latency shift register: stage 0 captures the issued address, the
  // last stage lines up with bram_dout.
  logic              pv_q [RD_LAT];
  logic [ADDR_W-1:0] pa_q [RD_LAT];
  logic [8:0]        px_q [RD_LAT];
  logic [7:0]        py_q [RD_LAT];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = VBLANK;
      VBLANK:  if (vcnt_q == 16'(VSYNC_CYC - 1)) state_d = SCAN;
      SCAN:    if (bram_addr_q == LAST_ADDR) state_d = DRAIN;
      DRAIN:   if (dcnt_q == 2'(RD_LAT - 1)) state_d = EOF;
      EOF:     state_d = enable ? VBLANK : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vcnt_q       <= '0;
      dcnt_q       <= '0;
      bram_addr_q  <= '0;
      ix_q         <= '0;
      iy_q         <= '0;
      vsync_q      <= 1'b1;
      frame_done_q <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
        pv_q[i] <= 1'b0;
        pa_q[i] <= '0;
        px_q[i] <= '0;
        py_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      vsync_q      <= (state_d == IDLE) || (state_d == VBLANK);
      frame_done_q <= (state_d == EOF);
      vcnt_q       <= (state_q == VBLANK) ? vcnt_q + 16'd1 : '0;
      dcnt_q       <= (state_q == DRAIN) ? dcnt_q + 2'd1 : '0;

      // Issue counters restart on every VBLANK->SCAN entry and freeze
      // after the last address so bram_addr holds outside the scan.
      if (state_q == VBLANK && state_d == SCAN) begin
        bram_addr_q <= '0;
        ix_q        <= '0;
        iy_q        <= '0;
      end else if (state_q == SCAN && state_d == SCAN) begin
        bram_addr_q <= bram_addr_q + 1'b1;
        if (ix_q == 9'(H_RES - 1)) begin
          ix_q <= '0;
          iy_q <= iy_q + 8'd1;
        end else begin
          ix_q <= ix_q + 9'd1;
        end
      end

      pv_q[0] <= (state_q == SCAN);
      pa_q[0] <= bram_addr_q;
      px_q[0] <= ix_q;
      py_q[0] <= iy_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pa_q[i] <= pa_q[i-1];
        px_q[i] <= px_q[i-1];
        py_q[i] <= py_q[i-1];
      end
    end
  end

  assign bram_addr   = bram_addr_q;
  assign vsync       = vsync_q;
  assign frame_done  = frame_done_q;
  assign pixel_valid = pv_q[RD_LAT-1];
  assign address     = frame_done_q ? EOF_ADDR : (pixel_valid ? pa_q[RD_LAT-1] : '0);
  assign x           = pixel_valid ? px_q[RD_LAT-1] : '0;
  assign y           = pixel_valid ? py_q[RD_LAT-1] : '0;

`ifdef TEST_PATTERN_EN
  logic in_box;
  assign in_box      = pixel_valid && (x >= 9'd8) && (x < 9'd12) && (y >= 8'd16) && (y < 8'd20);
  assign frame_pixel = in_box ? PIX_W'(12'h007) : '0;
`else
  assign frame_pixel = pixel_valid ? bram_dout : '0;
`endif

endmodule

// File: tb/tb_frame_scan_reader.sv
// tb/tb_frame_scan_reader.sv - self-checking bench for frame_scan_reader
`timescale 1ns/1ps
module tb_frame_scan_reader;

  localparam int H   = 24;
  localparam int V   = 22;
  localparam int PW  = 12;
  localparam int AW  = 10;
  localparam int RL  = 2;
  localparam int VS  = 5;
  localparam int N   = H * V;
  localparam int EOFPOS = VS + N + RL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [AW-1:0] bram_addr;
  logic [PW-1:0] bram_dout;
  logic          vsync;
  logic [AW-1:0] address;
  logic [PW-1:0] frame_pixel;
  logic          pixel_valid;
  logic [8:0]    x;
  logic [7:0]    y;
  logic          frame_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  frame_scan_reader #(
    .H_RES(H), .V_RES(V), .PIX_W(PW), .ADDR_W(AW), .RD_LAT(RL), .VSYNC_CYC(VS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .bram_addr(bram_addr), .bram_dout(bram_dout),
    .vsync(vsync), .address(address), .frame_pixel(frame_pixel),
    .pixel_valid(pixel_valid), .x(x), .y(y), .frame_done(frame_done)
  );

  // BRAM: random contents, RL-cycle read latency
  logic [PW-1:0] mem [N];
  logic [AW-1:0] lat_q [RL];
  always @(posedge clk) begin
    lat_q[0] <= bram_addr;
    for (int i = 1; i < RL; i++) lat_q[i] <= lat_q[i-1];
  end
  assign bram_dout = (int'(lat_q[RL-1]) < N) ? mem[lat_q[RL-1]] : '0;

  function automatic int pix_of(input int p);
`ifdef TEST_PATTERN_EN
    return ((p % H) >= 8 && (p % H) < 12 && (p / H) >= 16 && (p / H) < 20) ? 7 : 0;
`else
    return int'(mem[p]);
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame timeline model: pos = cycles since start of blanking, -1 = idle
  int pos = -1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)               pos <= -1;
    else if (pos < 0)         pos <= enable ? 0 : -1;
    else if (pos == EOFPOS)   pos <= enable ? 0 : -1;
    else                      pos <= pos + 1;
  end

  int held_ba = 0;
  initial begin
    forever begin
      int p;
      bit e_valid, e_done, e_vsync;
      @(negedge clk);
      if (!rst_n) held_ba = 0;
      if (pos >= VS && pos < VS + N) held_ba = pos - VS;
      p       = pos - VS - RL;
      e_valid = (pos >= 0) && (p >= 0) && (p < N);
      e_done  = (pos == EOFPOS);
      e_vsync = (pos < VS);
      chk("vsync", int'(vsync), int'(e_vsync));
      chk("bram_addr", int'(bram_addr), held_ba);
      chk("pixel_valid", int'(pixel_valid), int'(e_valid));
      chk("frame_done", int'(frame_done), int'(e_done));
      chk("address", int'(address), e_done ? N : (e_valid ? p : 0));
      chk("frame_pixel", int'(frame_pixel), e_valid ? pix_of(p) : 0);
      if (e_valid) begin
        chk("x", int'(x), p % H);
        chk("y", int'(y), p / H);
      end
    end
  end

  // mode 0: valid pixel at address a; mode 1: frame_done
  task automatic wait_for(input int mode, input int a, input string name);
    int n;
    bit hit;
    n = 0;
    hit = 0;
    while (!hit) begin
      @(negedge clk);
      if ((mode == 0 && pixel_valid && int'(address) == a) || (mode == 1 && frame_done))
        hit = 1;
      else begin
        n++;
        if (n > 5000) begin
          checks++;
          errors++;
          $display("FAIL %s: timed out waiting", name);
          hit = 1;
        end
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_vsync"}, int'(vsync), 1);
    chk({tag, "_bram_addr"}, int'(bram_addr), 0);
    chk({tag, "_address"}, int'(address), 0);
    chk({tag, "_pixel"}, int'(frame_pixel), 0);
    chk({tag, "_valid"}, int'(pixel_valid), 0);
    chk({tag, "_x"}, int'(x), 0);
    chk({tag, "_y"}, int'(y), 0);
    chk({tag, "_done"}, int'(frame_done), 0);
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < N; i++) mem[i] = PW'($urandom);

    repeat (3) @(posedge clk);
    #1 chk_reset_vals("reset");
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #2 enable = 1'b1;

    wait_for(0, H, "row1");
    chk("row1_x", int'(x), 0);
    chk("row1_y", int'(y), 1);
    wait_for(0, N - 1, "last_pix");
    chk("last_x", int'(x), H - 1);
    chk("last_y", int'(y), V - 1);
    wait_for(1, 0, "eof1");
    chk("eof_addr", int'(address), N);
    chk("eof_vsync", int'(vsync), 0);

    @(negedge clk);
    cnt = 0;
    while (vsync && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    chk("vblank_len", cnt, VS);
    chk("scan_start_addr", int'(bram_addr), 0);
    cnt = 0;
    while (!pixel_valid && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk("latency", cnt, RL);
    chk("first_addr", int'(address), 0);

    // drop enable mid-frame: frame completes, then idle
    wait_for(0, N / 2, "mid");
    enable = 1'b0;
    wait_for(1, 0, "eof_drop");
    chk("drop_eof_addr", int'(address), N);
    repeat (30) begin
      @(negedge clk);
      chk("idle_vsync", int'(vsync), 1);
      chk("idle_bram_addr", int'(bram_addr), N - 1);
      chk("idle_done", int'(frame_done), 0);
    end

    // random enable activity, checked by the model
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 199) == 0) enable = ~enable;
    end

    // async reset mid-frame
    @(posedge clk); #2 enable = 1'b1;
    wait_for(0, 100, "pix100");
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("midreset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    enable = 1'b0;
    repeat (10) @(posedge clk);
    #2 enable = 1'b1;
    wait_for(1, 0, "eof_after_reset");
    chk("post_reset_eof", int'(address), N);
    repeat (5) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
